// File: rtl/mvm_tile_sequencer.sv
// mvm_tile_sequencer: job sequencer for the SIZE x SIZE vector-multiplier array.
// Accepts a job, preloads the weight rows, streams the input vectors and tags
// result vectors after the fixed pipeline latency, then pulses done.
// Optional feature macro: WEIGHT_REUSE_EN (adds reuse_w to skip the weight
// preload when the array already holds a complete weight set).
module mvm_tile_sequencer #(
  parameter int SIZE  = 16,
  parameter int LAT   = 18,
  parameter int CNT_W = 6,
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VEC_W-1:0] num_vec,
  input  logic             abort,
`ifdef WEIGHT_REUSE_EN
  input  logic             reuse_w,
`endif
  output logic             ready,
  output logic             busy,
  output logic             w_load_en,
  output logic [CNT_W-1:0] w_addr,
  output logic             acc_clr,
  output logic             x_feed_en,
  output logic [VEC_W-1:0] x_addr,
  output logic             y_valid,
  output logic [VEC_W-1:0] y_addr,
  output logic             done
);

  // The shared row/timer counter must reach LAT + 2^VEC_W - 1 without wrapping.
  localparam int T_W = $clog2(LAT + (1 << VEC_W));
  localparam logic [T_W-1:0] LAT_T      = T_W'(LAT);
  localparam logic [T_W-1:0] LAST_ROW_T = T_W'(SIZE - 1);

  typedef enum logic [2:0] {IDLE, LOADW, STREAM, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [T_W-1:0]   cnt_q, cnt_d;
  logic [VEC_W-1:0] n_q, n_d;
  logic [T_W-1:0]   last_q_t, last_d_t;

  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             w_load_en_q, w_load_en_d;
  logic [CNT_W-1:0] w_addr_q, w_addr_d;
  logic             acc_clr_q, acc_clr_d;
  logic             x_feed_en_q, x_feed_en_d;
  logic [VEC_W-1:0] x_addr_q, x_addr_d;
  logic             y_valid_q, y_valid_d;
  logic [VEC_W-1:0] y_addr_q, y_addr_d;
  logic             done_q, done_d;

`ifdef WEIGHT_REUSE_EN
  logic             w_loaded_q, w_loaded_d;
`endif

  // Next state, counters and job length; abort overrides any other transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    last_q_t = LAT_T + T_W'(n_q) - T_W'(1);
`ifdef WEIGHT_REUSE_EN
    w_loaded_d = w_loaded_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = (num_vec == '0) ? VEC_W'(1) : num_vec;
          cnt_d   = '0;
          state_d = LOADW;
`ifdef WEIGHT_REUSE_EN
          if (reuse_w && w_loaded_q) begin
            state_d = STREAM;
          end
`endif
        end
      end
      LOADW: begin
        if (cnt_q == LAST_ROW_T) begin
          state_d = STREAM;
          cnt_d   = '0;
`ifdef WEIGHT_REUSE_EN
          w_loaded_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + T_W'(1);
        end
      end
      STREAM: begin
        cnt_d = cnt_q + T_W'(1);
        if (cnt_q == T_W'(n_q) - T_W'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == last_q_t) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + T_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
`ifdef WEIGHT_REUSE_EN
      if (state_q == LOADW) begin
        w_loaded_d = 1'b0;
      end
`endif
    end
  end

  // Registered outputs are decoded from the upcoming state and counter value.
  always_comb begin
    last_d_t    = LAT_T + T_W'(n_d) - T_W'(1);
    ready_d     = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    w_load_en_d = (state_d == LOADW);
    w_addr_d    = '0;
    acc_clr_d   = 1'b0;
    x_feed_en_d = 1'b0;
    x_addr_d    = '0;
    y_valid_d   = 1'b0;
    y_addr_d    = '0;
    done_d      = (state_d == DONE);
    if (state_d == LOADW) begin
      w_addr_d = CNT_W'(cnt_d);
    end
    if (state_d == STREAM) begin
      acc_clr_d   = (cnt_d == '0);
      x_feed_en_d = 1'b1;
      x_addr_d    = VEC_W'(cnt_d);
    end
    if (((state_d == STREAM) || (state_d == DRAIN)) &&
        (cnt_d >= LAT_T) && (cnt_d <= last_d_t)) begin
      y_valid_d = 1'b1;
      y_addr_d  = VEC_W'(cnt_d - LAT_T);
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      w_load_en_q <= 1'b0;
      w_addr_q    <= '0;
      acc_clr_q   <= 1'b0;
      x_feed_en_q <= 1'b0;
      x_addr_q    <= '0;
      y_valid_q   <= 1'b0;
      y_addr_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      w_load_en_q <= w_load_en_d;
      w_addr_q    <= w_addr_d;
      acc_clr_q   <= acc_clr_d;
      x_feed_en_q <= x_feed_en_d;
      x_addr_q    <= x_addr_d;
      y_valid_q   <= y_valid_d;
      y_addr_q    <= y_addr_d;
      done_q      <= done_d;
    end
  end

`ifdef WEIGHT_REUSE_EN
  // Remembers that a full weight set has been loaded since reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_loaded_q <= 1'b0;
    end else begin
      w_loaded_q <= w_loaded_d;
    end
  end
`endif

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign w_load_en = w_load_en_q;
  assign w_addr    = w_addr_q;
  assign acc_clr   = acc_clr_q;
  assign x_feed_en = x_feed_en_q;
  assign x_addr    = x_addr_q;
  assign y_valid   = y_valid_q;
  assign y_addr    = y_addr_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mvm_tile_sequencer.sv
// tb_mvm_tile_sequencer: scoreboard bench for mvm_tile_sequencer.
// Expected strobe events (edge number + index) are queued when a job is issued;
// a monitor on the falling edge pops and compares whenever a strobe is high.
module tb_mvm_tile_sequencer;

  localparam int SIZE  = 16;
  localparam int LAT   = 18;
  localparam int CNT_W = 6;
  localparam int VEC_W = 8;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [VEC_W-1:0] num_vec;
  logic             abort;
`ifdef WEIGHT_REUSE_EN
  logic             reuse_w;
`endif
  logic             ready;
  logic             busy;
  logic             w_load_en;
  logic [CNT_W-1:0] w_addr;
  logic             acc_clr;
  logic             x_feed_en;
  logic [VEC_W-1:0] x_addr;
  logic             y_valid;
  logic [VEC_W-1:0] y_addr;
  logic             done;

  int  edges  = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t wq[$];
  ev_t aq[$];
  ev_t xq[$];
  ev_t yq[$];
  ev_t dq[$];

  mvm_tile_sequencer #(
    .SIZE (SIZE),
    .LAT  (LAT),
    .CNT_W(CNT_W),
    .VEC_W(VEC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_vec  (num_vec),
    .abort    (abort),
`ifdef WEIGHT_REUSE_EN
    .reuse_w  (reuse_w),
`endif
    .ready    (ready),
    .busy     (busy),
    .w_load_en(w_load_en),
    .w_addr   (w_addr),
    .acc_clr  (acc_clr),
    .x_feed_en(x_feed_en),
    .x_addr   (x_addr),
    .y_valid  (y_valid),
    .y_addr   (y_addr),
    .done     (done)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to timestamp every observed strobe.
  always @(posedge clk) edges++;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edges);
    end
  endtask

  // Waits until the given edge has passed, then settles 1 ns after it.
  task automatic wait_edges(input int target);
    while (edges < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Queues every strobe a complete job accepted at edge e should produce.
  task automatic push_job(input int e, input int n, input bit skip);
    int base;
    base = skip ? e : e + SIZE;
    if (!skip) begin
      for (int r = 0; r < SIZE; r++) wq.push_back('{e + r, r});
    end
    aq.push_back('{base, 0});
    for (int i = 0; i < n; i++) xq.push_back('{base + i, i});
    for (int i = 0; i < n; i++) yq.push_back('{base + LAT + i, i});
    dq.push_back('{base + LAT + n, 0});
  endtask

  // Issues one job and lets it run to completion.
  task automatic apply_stimulus(input int nv, input bit reuse, input bit skip);
    int n;
    int e;
    int base;
    n = (nv == 0) ? 1 : nv;
    start   = 1'b1;
    num_vec = VEC_W'(nv);
`ifdef WEIGHT_REUSE_EN
    reuse_w = reuse;
`else
    if (reuse) $display("[TB] reuse_w not present in this build");
`endif
    e = edges + 1;
    push_job(e, n, skip);
    wait_edges(e);
    start = 1'b0;
    base = skip ? e : e + SIZE;
    wait_edges(base + LAT + n + 1);
    check_output("ready_after_done", int'(ready), 1);
    check_output("busy_after_done", int'(busy), 0);
  endtask

  // Scoreboard monitor: every active strobe must match the head of its queue.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (w_load_en) begin
        if (wq.size() == 0) check_output("w_load_unexpected", 1, 0);
        else begin
          e = wq.pop_front();
          check_output("w_load_edge", edges, e.cyc);
          check_output("w_addr", int'(w_addr), e.val);
        end
      end
      if (acc_clr) begin
        if (aq.size() == 0) check_output("acc_clr_unexpected", 1, 0);
        else begin
          e = aq.pop_front();
          check_output("acc_clr_edge", edges, e.cyc);
        end
      end
      if (x_feed_en) begin
        if (xq.size() == 0) check_output("x_feed_unexpected", 1, 0);
        else begin
          e = xq.pop_front();
          check_output("x_feed_edge", edges, e.cyc);
          check_output("x_addr", int'(x_addr), e.val);
        end
      end
      if (y_valid) begin
        if (yq.size() == 0) check_output("y_valid_unexpected", 1, 0);
        else begin
          e = yq.pop_front();
          check_output("y_valid_edge", edges, e.cyc);
          check_output("y_addr", int'(y_addr), e.val);
        end
      end
      if (done) begin
        if (dq.size() == 0) check_output("done_unexpected", 1, 0);
        else begin
          e = dq.pop_front();
          check_output("done_edge", edges, e.cyc);
          check_output("done_busy", int'(busy), 1);
        end
      end
    end
  end

  initial begin
    int e;
    int e2;
    rst     = 1'b1;
    start   = 1'b0;
    num_vec = '0;
    abort   = 1'b0;
`ifdef WEIGHT_REUSE_EN
    reuse_w = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_ready", int'(ready), 1);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_strobes", int'({w_load_en, acc_clr, x_feed_en, y_valid, done}), 0);
    check_output("reset_addrs", int'({w_addr, x_addr, y_addr}), 0);
    rst = 1'b0;
    wait_edges(edges + 2);

    $display("[TB] basic job num_vec=4");
    apply_stimulus(4, 1'b0, 1'b0);
    wait_edges(edges + 2);

    $display("[TB] num_vec=0 treated as 1");
    apply_stimulus(0, 1'b0, 1'b0);
    wait_edges(edges + 2);

    $display("[TB] num_vec=20 feed/result overlap");
    apply_stimulus(20, 1'b0, 1'b0);
    wait_edges(edges + 2);

    $display("[TB] abort at t=5 of STREAM");
    start   = 1'b1;
    num_vec = 8'd8;
    e = edges + 1;
    for (int r = 0; r < SIZE; r++) wq.push_back('{e + r, r});
    aq.push_back('{e + SIZE, 0});
    for (int i = 0; i <= 5; i++) xq.push_back('{e + SIZE + i, i});
    wait_edges(e);
    start = 1'b0;
    wait_edges(e + SIZE + 5);
    abort = 1'b1;
    wait_edges(e + SIZE + 6);
    abort = 1'b0;
    check_output("abort_ready", int'(ready), 1);
    check_output("abort_busy", int'(busy), 0);
    check_output("abort_strobes", int'({w_load_en, acc_clr, x_feed_en, y_valid, done}), 0);
    wait_edges(edges + 3);
    abort = 1'b1;
    wait_edges(edges + 1);
    abort = 1'b0;
    check_output("abort_idle_ready", int'(ready), 1);
    apply_stimulus(3, 1'b0, 1'b0);
    wait_edges(edges + 2);

    $display("[TB] start held high, back-to-back jobs");
    start   = 1'b1;
    num_vec = 8'd2;
    e  = edges + 1;
    e2 = e + SIZE + LAT + 2 + 2;
    push_job(e, 2, 1'b0);
    push_job(e2, 2, 1'b0);
    wait_edges(e2);
    start = 1'b0;
    wait_edges(e2 + SIZE + LAT + 2 + 1);
    check_output("b2b_ready", int'(ready), 1);
    wait_edges(edges + 2);

`ifdef WEIGHT_REUSE_EN
    $display("[TB] weight reuse");
    rst = 1'b1;
    wait_edges(edges + 2);
    rst = 1'b0;
    wait_edges(edges + 2);
    apply_stimulus(3, 1'b1, 1'b0);
    wait_edges(edges + 2);
    apply_stimulus(3, 1'b1, 1'b1);
    wait_edges(edges + 2);
`endif

    wait_edges(edges + 5);
    check_output("w_queue_left", wq.size(), 0);
    check_output("acc_queue_left", aq.size(), 0);
    check_output("x_queue_left", xq.size(), 0);
    check_output("y_queue_left", yq.size(), 0);
    check_output("done_queue_left", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
